scan_mem_arbiter: RTL and testbench
===================================

Name: scan_mem_arbiter

Overview:
- Sequences the load phase and owns the single-port weight/feature SRAM (512 x 32) shared by two requesters.
- Requester 1: the scan-chain memory loader, which emits an active-low write strobe, a word and an address.
- Requester 2: the accelerator read port.
- Phase FSM: scan writes are accepted during load; accelerator reads are granted only after a complete load. Load completion, word count and overrun status go to the top-level control.

Parameters:
- ADDR_W, 9, SRAM address width.
- DATA_W, 32, SRAM word width.
- EXPECTED_WORDS, 512, words required for a complete load (1..2^ADDR_W).

Ports:
- scan_clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- scan_enable  input  1  load phase request from scan interface.
- ld_sel_n  input  1  loader write strobe, active-low, one cycle per word.
- ld_addr  input  ADDR_W  loader word address.
- ld_data  input  DATA_W  loader word.
- acc_req  input  1  accelerator read request.
- acc_addr  input  ADDR_W  accelerator read address.
- acc_gnt  output  1  read granted this cycle (combinational).
- acc_rvalid  output  1  acc_rdata valid (1 cycle after grant).
- acc_rdata  output  DATA_W  read data, passthrough of mem_rdata.
- mem_cen  output  1  SRAM chip enable, active-low.
- mem_wen  output  1  SRAM write enable, active-low.
- mem_addr  output  ADDR_W  SRAM address.
- mem_wdata  output  DATA_W  SRAM write data.
- mem_rdata  input  DATA_W  SRAM read data, valid 1 cycle after a read.
- load_done  output  1  complete load present; reads permitted.
- word_count  output  ADDR_W+1  words accepted in current load.
- overrun  output  1  sticky: write attempted after EXPECTED_WORDS.

Behaviour:
- FSM states: IDLE, LOAD, RUN. Reset -> IDLE.
- Reset values: word_count=0, load_done=0, overrun=0, acc_rvalid=0, mem_cen=1, mem_wen=1, mem_addr=0, mem_wdata=0.
- IDLE -> LOAD when scan_enable=1. On this transition: clear word_count and overrun, drop load_done.
- LOAD -> RUN when scan_enable=0 and word_count==EXPECTED_WORDS. Set load_done=1.
- LOAD -> IDLE when scan_enable=0 and word_count<EXPECTED_WORDS. Partial load: load_done stays 0.
- RUN -> LOAD when scan_enable=1 (reload). Clear word_count and overrun, drop load_done the same edge.
- Write accepted when state==LOAD && scan_enable==1 && ld_sel_n==0 && word_count<EXPECTED_WORDS:
  - mem_cen=0, mem_wen=0, mem_addr=ld_addr, mem_wdata=ld_data, combinational in that cycle; SRAM samples at posedge.
  - word_count increments at that edge.
- ld_sel_n==0 in LOAD with word_count==EXPECTED_WORDS: write suppressed (mem_cen=1), overrun set, word_count holds (saturates).
- ld_sel_n ignored in IDLE, in RUN, and in any cycle with scan_enable=0 (loader output is stale then).
- Read grant: acc_gnt = (state==RUN) && acc_req && !reset. Reads never occur in LOAD or IDLE; a write always wins by construction.
- On grant: mem_cen=0, mem_wen=1, mem_addr=acc_addr. acc_rvalid registered to 1 at the next edge; acc_rdata = mem_rdata. Back-to-back reads give one rvalid per cycle.
- A grant in the last RUN cycle (scan_enable rising) still produces acc_rvalid next cycle.
- No access: mem_cen=1, mem_wen=1, mem_addr/mem_wdata hold last values.
- Reset mid-load or mid-run: FSM -> IDLE next edge, all outputs to reset values; a pending acc_rvalid is cancelled.

Optional Feature:
- Macro: SCAN_MEM_CHECKSUM_EN.
- When defined:
  - Extra output load_csum [DATA_W-1:0] = XOR of every accepted write word in the current load.
  - Cleared on reset and on entry to LOAD; updates on each accepted write; frozen in RUN.
  - Suppressed (overrun) writes are excluded.
- When undefined: port absent, no checksum logic.

Test Plan:
- Reset, then scan_enable=1, 512 strobes at addr 0..511 with data=addr*3, then scan_enable=0 -> word_count=512, load_done=1, state RUN, overrun=0; SRAM model holds all 512 words.
- In RUN, acc_req for 3 consecutive cycles, addr 5,6,7 -> acc_gnt=1 each cycle; acc_rvalid on the next 3 cycles with data 15,18,21.
- Load only 100 words, then drop scan_enable -> state IDLE, load_done=0, word_count=100; acc_req=1 -> acc_gnt=0, mem_cen=1.
- Full 512-word load plus a 513th strobe (data 0xDEADBEEF) -> no SRAM write, overrun=1, word_count=512; next reload entry clears overrun to 0.
- Assert reset at word 200 of a load -> next edge: IDLE, word_count=0, mem_cen=1; strobe while scan_enable=0 -> no write.
- With SCAN_MEM_CHECKSUM_EN: write 0x0000000F, 0x000000F0, 0x0000FF00 -> load_csum=0x0000FFFF.

Source files
------------

// File: rtl/scan_mem_arbiter_if.sv
// Bus bundle between the scan-memory arbiter and its surroundings: the
// scan loader, the accelerator read port, the SRAM macro and the load
// status outputs. The slave modport is the arbiter's view; master is the
// environment's view.
// Optional: SCAN_MEM_CHECKSUM_EN adds the load_csum status signal.
interface scan_mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              scan_enable;
  logic              ld_sel_n;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              acc_req;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_gnt;
  logic              acc_rvalid;
  logic [DATA_W-1:0] acc_rdata;
  logic              mem_cen;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              load_done;
  logic [ADDR_W:0]   word_count;
  logic              overrun;
`ifdef SCAN_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] load_csum;
`endif

  modport slave (
    input  scan_enable, ld_sel_n, ld_addr, ld_data,
    input  acc_req, acc_addr, mem_rdata,
    output acc_gnt, acc_rvalid, acc_rdata,
    output mem_cen, mem_wen, mem_addr, mem_wdata,
    output load_done, word_count, overrun
`ifdef SCAN_MEM_CHECKSUM_EN
    , output load_csum
`endif
  );

  modport master (
    output scan_enable, ld_sel_n, ld_addr, ld_data,
    output acc_req, acc_addr, mem_rdata,
    input  acc_gnt, acc_rvalid, acc_rdata,
    input  mem_cen, mem_wen, mem_addr, mem_wdata,
    input  load_done, word_count, overrun
`ifdef SCAN_MEM_CHECKSUM_EN
    , input load_csum
`endif
  );
endinterface

// File: rtl/scan_mem_arbiter.sv
// scan_mem_arbiter: owns the single-port weight/feature SRAM. The scan
// loader writes it during the LOAD phase; the accelerator may read it only
// in RUN, i.e. after a complete load of EXPECTED_WORDS words. Because the
// two requesters are active in disjoint phases, no cycle ever has both a
// write and a read candidate.
// Optional: define SCAN_MEM_CHECKSUM_EN to add load_csum, the XOR of all
// words accepted in the current load.
module scan_mem_arbiter #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 32,
  parameter int EXPECTED_WORDS = 512
) (
  input  logic              scan_clk,
  input  logic              reset,
  scan_mem_arbiter_if.slave bus
);

  localparam logic [ADDR_W:0] EXP_CNT = (ADDR_W+1)'(EXPECTED_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } phase_t;

  phase_t            state_q;
  phase_t            state_d;
  logic              enter_load;
  logic              enter_run;

  logic [ADDR_W:0]   cnt_q;
  logic              done_q;
  logic              ovr_q;
  logic              rd_vld_p1;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              strobe;
  logic              wr_acc;
  logic              wr_ovr;
  logic              rd_gnt;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // Word counter never passes the expected load size.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    return (c < EXP_CNT) ? c + (ADDR_W+1)'(1) : c;
  endfunction

  // Phase register.
  always_ff @(posedge scan_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Phase transitions; a new load starts from IDLE or as a reload from RUN.
  always_comb begin
    state_d    = state_q;
    enter_load = 1'b0;
    enter_run  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.scan_enable) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        if (!bus.scan_enable) begin
          if (cnt_q == EXP_CNT) begin
            state_d   = RUN;
            enter_run = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RUN: begin
        if (bus.scan_enable) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Access decode: the loader strobe is only trusted while scan_enable is
  // high in LOAD; nothing reaches the SRAM while reset is asserted.
  always_comb begin
    strobe  = !reset && (state_q == LOAD) && bus.scan_enable && !bus.ld_sel_n;
    wr_acc  = strobe && (cnt_q < EXP_CNT);
    wr_ovr  = strobe && !(cnt_q < EXP_CNT);
    rd_gnt  = !reset && (state_q == RUN) && bus.acc_req;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (wr_acc) begin
      addr_d  = bus.ld_addr;
      wdata_d = bus.ld_data;
    end else if (rd_gnt) begin
      addr_d  = bus.acc_addr;
    end
  end

  assign bus.mem_cen    = !(wr_acc || rd_gnt);
  assign bus.mem_wen    = !wr_acc;
  assign bus.mem_addr   = addr_d;
  assign bus.mem_wdata  = wdata_d;
  assign bus.acc_gnt    = rd_gnt;
  assign bus.acc_rvalid = rd_vld_p1;
  assign bus.acc_rdata  = bus.mem_rdata;
  assign bus.load_done  = done_q;
  assign bus.word_count = cnt_q;
  assign bus.overrun    = ovr_q;

  // Load status: counter, completion flag and sticky overrun.
  always_ff @(posedge scan_clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else if (enter_load) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (wr_acc)    cnt_q  <= sat_inc(cnt_q);
      if (wr_ovr)    ovr_q  <= 1'b1;
      if (enter_run) done_q <= 1'b1;
    end
  end

  // ---- stage p0 -> p1: SRAM read latency, rvalid follows the grant ----
  // Read-valid pipeline; reset cancels a pending response.
  always_ff @(posedge scan_clk) begin
    if (reset) rd_vld_p1 <= 1'b0;
    else       rd_vld_p1 <= rd_gnt;
  end

  // Address/data hold registers so idle cycles keep the last bus values.
  always_ff @(posedge scan_clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (wr_acc || rd_gnt) addr_q  <= addr_d;
      if (wr_acc)           wdata_q <= bus.ld_data;
    end
  end

`ifdef SCAN_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  // Running XOR of accepted words; suppressed overrun writes are excluded.
  always_ff @(posedge scan_clk) begin
    if (reset || enter_load) csum_q <= '0;
    else if (wr_acc)         csum_q <= csum_q ^ bus.ld_data;
  end

  assign bus.load_csum = csum_q;
`endif

endmodule

// File: tb/tb_scan_mem_arbiter.sv
// Self-checking bench for scan_mem_arbiter: directed test-plan sequences
// with literal expectations, then randomized traffic. A phase-level model
// with a shadow memory predicts every output on every cycle.
module tb_scan_mem_arbiter;
  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int EXP = 512;
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;

  logic scan_clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  scan_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  scan_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .EXPECTED_WORDS(EXP)) dut (
    .scan_clk (scan_clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial scan_clk = 1'b0;
  always #5 scan_clk = ~scan_clk;

  // SRAM macro model: write or registered read on posedge.
  logic [DW-1:0] sram [EXP];
  initial begin
    forever begin
      @(posedge scan_clk);
      if (!bus.mem_cen) begin
        if (!bus.mem_wen) sram[bus.mem_addr] <= bus.mem_wdata;
        else              bus.mem_rdata      <= sram[bus.mem_addr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_phase;
  int            m_cnt;
  bit            m_done, m_ovr, m_known;
  bit            m_rvalid, m_rd_known;
  logic [DW-1:0] m_rd_data;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wdata;
  logic [DW-1:0] m_csum;
  logic [DW-1:0] shadow [EXP];
  bit            shadow_known [EXP];

  task automatic model_step();
    bit            st, wr, ov, gn;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    st = !reset && m_phase == P_LOAD && bus.scan_enable && !bus.ld_sel_n;
    wr = st && m_cnt < EXP;
    ov = st && m_cnt >= EXP;
    gn = !reset && m_phase == P_RUN && bus.acc_req;
    ea = wr ? bus.ld_addr : (gn ? bus.acc_addr : m_last_addr);
    ed = wr ? bus.ld_data : m_last_wdata;
    if (m_known) begin
      check("acc_gnt",    64'(bus.acc_gnt),    64'(gn));
      check("mem_cen",    64'(bus.mem_cen),    64'(!(wr || gn)));
      check("mem_wen",    64'(bus.mem_wen),    64'(!wr));
      check("mem_addr",   64'(bus.mem_addr),   64'(ea));
      check("mem_wdata",  64'(bus.mem_wdata),  64'(ed));
      check("word_count", 64'(bus.word_count), 64'(m_cnt));
      check("load_done",  64'(bus.load_done),  64'(m_done));
      check("overrun",    64'(bus.overrun),    64'(m_ovr));
      check("acc_rvalid", 64'(bus.acc_rvalid), 64'(m_rvalid));
      if (m_rvalid && m_rd_known) check("acc_rdata", 64'(bus.acc_rdata), 64'(m_rd_data));
`ifdef SCAN_MEM_CHECKSUM_EN
      check("load_csum",  64'(bus.load_csum),  64'(m_csum));
`endif
    end
    if (reset) begin
      m_known = 1'b1;
      m_phase = P_IDLE; m_cnt = 0; m_done = 0; m_ovr = 0; m_rvalid = 0;
      m_last_addr = '0; m_last_wdata = '0; m_csum = '0;
    end else begin
      m_rvalid = gn;
      if (gn) begin
        m_rd_known = shadow_known[bus.acc_addr];
        m_rd_data  = shadow[bus.acc_addr];
      end
      if (wr) begin
        shadow[bus.ld_addr]       = bus.ld_data;
        shadow_known[bus.ld_addr] = 1'b1;
        m_cnt++;
        m_csum ^= bus.ld_data;
      end
      if (ov) m_ovr = 1;
      if (wr || gn) m_last_addr = ea;
      m_last_wdata = ed;
      if ((m_phase == P_IDLE || m_phase == P_RUN) && bus.scan_enable) begin
        m_phase = P_LOAD; m_cnt = 0; m_ovr = 0; m_done = 0; m_csum = '0;
      end else if (m_phase == P_LOAD && !bus.scan_enable) begin
        if (m_cnt == EXP) begin m_phase = P_RUN; m_done = 1; end
        else m_phase = P_IDLE;
      end
    end
  endtask

  // Compare process: every negedge, away from the active edge.
  initial begin
    m_known = 0; m_phase = P_IDLE; m_cnt = 0; m_rvalid = 0; m_rd_known = 0;
    m_csum = '0; m_last_addr = '0; m_last_wdata = '0; m_done = 0; m_ovr = 0;
    for (int i = 0; i < EXP; i++) begin
      shadow_known[i] = 1'b0;
      shadow[i] = '0;
    end
    forever begin
      @(negedge scan_clk);
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge scan_clk);
    #1;
  endtask

  task automatic strobe(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ld_sel_n = 1'b0;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    tick();
    bus.ld_sel_n = 1'b1;
  endtask

  task automatic full_load();
    bus.scan_enable = 1'b1;
    tick();
    for (int i = 0; i < EXP; i++) strobe(AW'(i), DW'(i * 3));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.scan_enable = 1'b0;
    bus.ld_sel_n = 1'b1;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    bus.acc_req = 1'b0;
    bus.acc_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst word_count", 64'(bus.word_count), 64'd0);
    check("rst load_done",  64'(bus.load_done),  64'd0);
    check("rst overrun",    64'(bus.overrun),    64'd0);
    check("rst mem_cen",    64'(bus.mem_cen),    64'd1);
    check("rst acc_rvalid", 64'(bus.acc_rvalid), 64'd0);

    // Complete load of addr*3.
    full_load();
    bus.scan_enable = 1'b0;
    tick();
    check("full word_count", 64'(bus.word_count), 64'd512);
    check("full load_done",  64'(bus.load_done),  64'd1);
    check("full overrun",    64'(bus.overrun),    64'd0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < EXP; i++) if (sram[i] !== DW'(i * 3)) bad++;
      check("sram contents bad words", 64'(bad), 64'd0);
    end

    // Three back-to-back reads.
    bus.acc_req = 1'b1;
    bus.acc_addr = AW'(5);
    #1 check("gnt addr5", 64'(bus.acc_gnt), 64'd1);
    tick();
    check("rvalid 5", 64'(bus.acc_rvalid), 64'd1);
    check("rdata 5",  64'(bus.acc_rdata),  64'd15);
    bus.acc_addr = AW'(6);
    #1 check("gnt addr6", 64'(bus.acc_gnt), 64'd1);
    tick();
    check("rdata 6",  64'(bus.acc_rdata),  64'd18);
    bus.acc_addr = AW'(7);
    #1 check("gnt addr7", 64'(bus.acc_gnt), 64'd1);
    tick();
    bus.acc_req = 1'b0;
    check("rvalid 7", 64'(bus.acc_rvalid), 64'd1);
    check("rdata 7",  64'(bus.acc_rdata),  64'd21);
    tick();
    check("rvalid drop", 64'(bus.acc_rvalid), 64'd0);

    // Partial load of 100 words: no read permission.
    bus.scan_enable = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) strobe(AW'(i), DW'(i * 3));
    bus.scan_enable = 1'b0;
    tick();
    check("partial word_count", 64'(bus.word_count), 64'd100);
    check("partial load_done",  64'(bus.load_done),  64'd0);
    bus.acc_req = 1'b1;
    #1;
    check("partial gnt",     64'(bus.acc_gnt), 64'd0);
    check("partial mem_cen", 64'(bus.mem_cen), 64'd1);
    tick();
    bus.acc_req = 1'b0;

    // Overrun: 513th strobe is suppressed.
    full_load();
    strobe(AW'(0), 32'hDEADBEEF);
    check("ovr overrun",    64'(bus.overrun),    64'd1);
    check("ovr word_count", 64'(bus.word_count), 64'd512);
    check("ovr sram[0]",    64'(sram[0]),        64'd0);
    bus.scan_enable = 1'b0;
    tick();
    check("ovr load_done",  64'(bus.load_done),  64'd1);
    bus.scan_enable = 1'b1;
    tick();
    check("reload overrun",    64'(bus.overrun),    64'd0);
    check("reload word_count", 64'(bus.word_count), 64'd0);
    check("reload load_done",  64'(bus.load_done),  64'd0);

    // Reset at word 200 of the reload.
    for (int i = 0; i < 200; i++) strobe(AW'(i), DW'(i * 3));
    reset = 1'b1;
    bus.scan_enable = 1'b0;
    tick();
    reset = 1'b0;
    check("midrst word_count", 64'(bus.word_count), 64'd0);
    check("midrst mem_cen",    64'(bus.mem_cen),    64'd1);
    check("midrst load_done",  64'(bus.load_done),  64'd0);
    bus.ld_sel_n = 1'b0;
    bus.ld_addr  = AW'(3);
    bus.ld_data  = 32'h55;
    #1 check("stale strobe mem_cen", 64'(bus.mem_cen), 64'd1);
    tick();
    bus.ld_sel_n = 1'b1;
    tick();
    check("stale strobe sram[3]", 64'(sram[3]), 64'd9);

`ifdef SCAN_MEM_CHECKSUM_EN
    bus.scan_enable = 1'b1;
    tick();
    strobe(AW'(0), 32'h0000000F);
    strobe(AW'(1), 32'h000000F0);
    strobe(AW'(2), 32'h0000FF00);
    bus.scan_enable = 1'b0;
    tick();
    check("load_csum", 64'(bus.load_csum), 64'h0000FFFF);
`endif

    // Randomized traffic with occasional phase changes and resets.
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 499) == 0) bus.scan_enable = ~bus.scan_enable;
      reset        = ($urandom_range(0, 999) == 0);
      bus.ld_sel_n = ($urandom_range(0, 3) == 0);
      bus.ld_addr  = AW'($urandom);
      bus.ld_data  = DW'($urandom);
      bus.acc_req  = 1'($urandom_range(0, 1));
      bus.acc_addr = AW'($urandom);
      tick();
    end
    reset = 1'b0;
    bus.ld_sel_n = 1'b1;
    bus.acc_req = 1'b0;
    bus.scan_enable = 1'b0;
    tick();

    // Full load of random data, then random reads in RUN.
    bus.scan_enable = 1'b1;
    tick();
    for (int i = 0; i < EXP; i++) strobe(AW'(i), DW'($urandom));
    bus.scan_enable = 1'b0;
    tick();
    for (int c = 0; c < 300; c++) begin
      bus.acc_req  = 1'($urandom_range(0, 1));
      bus.acc_addr = AW'($urandom);
      tick();
    end
    bus.acc_req = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
